// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and widths for the two-requester BCD conversion arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package bcd_convert_arbiter_pkg;

    localparam int OP_W    = 5;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/bcd_convert_arbiter_bcd_converter.sv
// Combinational 5-bit binary to two-digit BCD converter (0..31).
// Latency: 0 cycles. Backpressure: none, pure combinational.
module bcd_converter
    import bcd_convert_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]    bin,
    output logic [DIGIT_W-1:0] ten,
    output logic [DIGIT_W-1:0] one
);

    // Range is capped at 31, so three compare-and-subtract steps cover every tens value.
    always_comb begin
        ten = 4'd0;
        one = DIGIT_W'(bin);
        if (bin >= 5'd30) begin
            ten = 4'd3;
            one = DIGIT_W'(bin - 5'd30);
        end else if (bin >= 5'd20) begin
            ten = 4'd2;
            one = DIGIT_W'(bin - 5'd20);
        end else if (bin >= 5'd10) begin
            ten = 4'd1;
            one = DIGIT_W'(bin - 5'd10);
        end
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Arbitrates two four-phase REQ/ACK requesters onto one BCD converter; BCD_STATS_EN adds grant counters.
// Latency: REQ seen at grant edge k -> ACK high after edge k+2. Backpressure: losing REQ waits pending in IDLE.
module bcd_convert_arbiter
    import bcd_convert_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [OP_W-1:0]    in0,
    input  logic               req1,
    input  logic [OP_W-1:0]    in1,
    output logic               ack0,
    output logic               ack1,
    output logic [DIGIT_W-1:0] ten,
    output logic [DIGIT_W-1:0] one,
    output req_id_t            gnt_id,
    output logic               busy
`ifdef BCD_STATS_EN
    ,
    output logic [7:0]         cnt0,
    output logic [7:0]         cnt1
`endif
);

    state_t              state;
    state_t              next_state;
    logic                grant;
    req_id_t             grant_id;
    req_id_t             last;
    logic                gnt_req;
    logic [OP_W-1:0]     operand;
    logic [DIGIT_W-1:0]  conv_ten;
    logic [DIGIT_W-1:0]  conv_one;

    bcd_converter u_conv (
        .bin (operand),
        .ten (conv_ten),
        .one (conv_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        gnt_req    = gnt_id ? req1 : req0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant    = 1'b1;
                    grant_id = RR_EN ? ~last : 1'b0;
                end else if (req0) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (req1) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) next_state = CONV;
            end
            CONV:    next_state = RESP;
            RESP:    if (!gnt_req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ACK is registered, so it rises one cycle into RESP and falls on the edge that leaves RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand <= '0;
            gnt_id  <= 1'b0;
            ten     <= '0;
            one     <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            last    <= 1'b1;
        end else begin
            if (grant) begin
                operand <= grant_id ? in1 : in0;
                gnt_id  <= grant_id;
            end
            if (state == CONV) begin
                ten <= conv_ten;
                one <= conv_one;
            end
            if (state == RESP && gnt_req) begin
                ack0 <= (gnt_id == 1'b0);
                ack1 <= (gnt_id == 1'b1);
            end else begin
                ack0 <= 1'b0;
                ack1 <= 1'b0;
            end
            if (state == RESP && !gnt_req) last <= gnt_id;
        end
    end

    assign busy = (state != IDLE);

`ifdef BCD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (grant) begin
            if (grant_id == 1'b0 && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
            if (grant_id == 1'b1 && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
